serial_rx_ctrl: RTL and testbench

Receive-side bit-timing controller for the serial input path. It synchronizes a raw asynchronous serial line and detects start bits. It times each bit period and emits a one-cycle `shift_enable` with the sampled bit at mid-bit, so the downstream serial-to-parallel shift register (LSB-first, right-shift mode) assembles the data word. It then checks the stop bit and reports packet completion, framing errors and overruns to the consumer of the parallel word.

---
 rtl/serial_rx_ctrl.sv | 171 +++++++++++++++++
 tb/tb_serial_rx_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_ctrl.sv
`default_nettype none
//============================================================================
// Module   : serial_rx_ctrl
// Brief    : Serial receive bit-timing controller: line sync, start detect,
//            mid-bit sampling, stop-bit check and consumer status flags.
// Revision : 1.0 - initial release
//============================================================================
module serial_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_enable,
  output logic sample_bit,
  output logic packet_done,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic busy
);

  localparam int c_tw    = $clog2(CLKS_PER_BIT);
  localparam int c_cw    = $clog2(DATA_BITS + 1);
  localparam logic [c_tw-1:0] c_half     = c_tw'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_tw-1:0] c_last     = c_tw'(CLKS_PER_BIT - 1);
  localparam logic [c_cw-1:0] c_bit_last = c_cw'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_tw-1:0] r_timer, w_timer_nxt;
  logic [c_cw-1:0] r_bitcnt, w_bitcnt_nxt;
  logic            r_sync, r_line_s, r_line_d;
  logic            r_shift_en, w_shift_en_nxt;
  logic            r_sample, w_sample_nxt;
  logic            r_done, w_done_nxt;
  logic            r_ready, w_ready_nxt;
  logic            r_ferr, w_ferr_nxt;
  logic            r_ovr, w_ovr_nxt;
  logic            r_busy;
  logic            w_start_edge;

  // Synchronizer idles high so reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_sync   <= 1'b1;
      r_line_s <= 1'b1;
      r_line_d <= 1'b1;
    end else begin
      r_sync   <= serial_in;
      r_line_s <= r_sync;
      r_line_d <= r_line_s;
    end
  end

  assign w_start_edge = r_line_d & ~r_line_s;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bitcnt   <= '0;
      r_shift_en <= 1'b0;
      r_sample   <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift_en <= w_shift_en_nxt;
      r_sample   <= w_sample_nxt;
      r_done     <= w_done_nxt;
      r_ready    <= w_ready_nxt;
      r_ferr     <= w_ferr_nxt;
      r_ovr      <= w_ovr_nxt;
      r_busy     <= (r_state != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_en_nxt = 1'b0;
    w_sample_nxt   = 1'b0;
    w_done_nxt     = 1'b0;
    w_ready_nxt    = r_ready;
    w_ferr_nxt     = r_ferr;
    w_ovr_nxt      = r_ovr;

    if (data_read) begin
      w_ready_nxt = 1'b0;
      w_ovr_nxt   = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = S_START;
          w_timer_nxt = '0;
          w_ferr_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (r_timer == c_half) begin
          w_timer_nxt  = '0;
          w_bitcnt_nxt = '0;
          w_state_nxt  = r_line_s ? S_IDLE : S_DATA;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_DATA: begin
        if (r_timer == c_last) begin
          w_timer_nxt    = '0;
          w_shift_en_nxt = 1'b1;
          w_sample_nxt   = r_line_s;
          w_bitcnt_nxt   = r_bitcnt + 1'b1;
          if (r_bitcnt == c_bit_last) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_STOP: begin
        if (r_timer == c_last) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
          if (r_line_s) begin
            w_done_nxt  = 1'b1;
            w_ready_nxt = 1'b1;
            // A read landing on the completion cycle consumes the old word.
            if (r_ready && !data_read) begin
              w_ovr_nxt = 1'b1;
            end
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign shift_enable  = r_shift_en;
  assign sample_bit    = r_sample;
  assign packet_done   = r_done;
  assign data_ready    = r_ready;
  assign framing_error = r_ferr;
  assign overrun_error = r_ovr;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_serial_rx_ctrl
// Brief    : Self-checking bench for serial_rx_ctrl with a packet-level model.
// Revision : 1.0 - initial release
//============================================================================
module tb_serial_rx_ctrl;

  localparam int CLKS_PER_BIT = 10;
  localparam int DATA_BITS    = 8;

  logic clk = 1'b0;
  logic n_rst, serial_in, data_read;
  logic shift_enable, sample_bit, packet_done, data_ready, framing_error, overrun_error, busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int   pulse_q[$];
  logic bit_q[$];
  int   done_q[$];

  // Packet-level reference flags
  logic m_ready, m_fe, m_ov;

  // Observations from the most recent frame
  int         o_np, o_nd, o_first, o_gaps_bad, o_done_gap;
  logic [7:0] o_word;
  logic       o_mid_busy, o_mid_fe;

  serial_rx_ctrl #(.CLKS_PER_BIT(CLKS_PER_BIT), .DATA_BITS(DATA_BITS)) dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .data_read(data_read),
    .shift_enable(shift_enable), .sample_bit(sample_bit), .packet_done(packet_done),
    .data_ready(data_ready), .framing_error(framing_error),
    .overrun_error(overrun_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (shift_enable === 1'b1) begin
      pulse_q.push_back(cyc);
      bit_q.push_back(sample_bit);
    end
    if (packet_done === 1'b1) done_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end, want finish");
    $fatal(1, "timeout");
  end

  task automatic pulse_read();
    @(negedge clk); data_read = 1'b1;
    @(negedge clk); data_read = 1'b0;
    m_ready = 1'b0;
    m_ov    = 1'b0;
  endtask

  // Drives start(0), data LSB-first, stop; optionally raises data_read on the
  // completion cycle (10 clocks after the last shift pulse) or aborts after
  // abort_at shift pulses with the line returned to idle.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic rd_at_done,
                            input int idle_after, input int abort_at);
    int p0, d0, base, last;
    logic [9:0] fr;
    p0 = pulse_q.size();
    d0 = done_q.size();
    fr = {stop, data, 1'b0};
    base = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (i == 0 && j == 0) base = cyc;
        if (abort_at != 0 && pulse_q.size() - p0 >= abort_at) begin
          serial_in = 1'b1;
          data_read = 1'b0;
          return;
        end
        serial_in = fr[i];
        last = (pulse_q.size() > 0) ? pulse_q[pulse_q.size()-1] : -100;
        data_read = rd_at_done && (pulse_q.size() - p0 == DATA_BITS) && (cyc == last + 9);
        if (i == 1 && j == 0) begin
          o_mid_busy = busy;
          o_mid_fe   = framing_error;
        end
      end
    end
    data_read = 1'b0;
    m_fe = 1'b0;
    if (stop) begin
      if (rd_at_done) m_ov = 1'b0;
      else if (m_ready) m_ov = 1'b1;
      m_ready = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
    o_np = pulse_q.size() - p0;
    o_nd = done_q.size() - d0;
    o_word = 8'h00;
    o_gaps_bad = 0;
    for (int k = p0; k < pulse_q.size(); k++) begin
      o_word = {bit_q[k], o_word[7:1]};
      if (k > p0 && pulse_q[k] - pulse_q[k-1] != CLKS_PER_BIT) o_gaps_bad++;
    end
    o_first = (o_np > 0) ? pulse_q[p0] - base : -1;
    o_done_gap = (o_nd > 0 && o_np > 0) ? done_q[d0] - pulse_q[pulse_q.size()-1] : -1;
    repeat (idle_after) begin
      @(negedge clk);
      serial_in = 1'b1;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; serial_in = 1'b1; data_read = 1'b0;
    m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({shift_enable, sample_bit, packet_done, data_ready, framing_error, overrun_error, busy} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {shift_enable, sample_bit, packet_done, data_ready, framing_error, overrun_error, busy});
    end
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    compared++;
    if ({busy, data_ready, shift_enable} !== 3'b0) begin
      mismatched++; $display("FAIL idle_after_reset: got %b want 000", {busy, data_ready, shift_enable});
    end
  endtask

  task automatic test_good_byte();
    send_frame(8'hA5, 1'b1, 1'b0, 3, 0);
    compared++; if (o_np !== 8) begin mismatched++; $display("FAIL good_pulses: got %0d want 8", o_np); end
    compared++; if (o_word !== 8'hA5) begin mismatched++; $display("FAIL good_word: got %h want a5", o_word); end
    compared++; if (o_gaps_bad !== 0) begin mismatched++; $display("FAIL good_spacing: got %0d bad gaps want 0", o_gaps_bad); end
    compared++; if (o_first < 15 || o_first > 20) begin mismatched++; $display("FAIL good_first_pulse: got offset %0d want 15..20", o_first); end
    compared++; if (o_nd !== 1) begin mismatched++; $display("FAIL good_done_count: got %0d want 1", o_nd); end
    compared++; if (o_done_gap !== 10) begin mismatched++; $display("FAIL good_done_gap: got %0d want 10", o_done_gap); end
    compared++; if (o_mid_busy !== 1'b1) begin mismatched++; $display("FAIL good_busy: got %b want 1", o_mid_busy); end
    compared++;
    if ({data_ready, framing_error, overrun_error} !== {m_ready, m_fe, m_ov}) begin
      mismatched++; $display("FAIL good_flags: got %b want %b", {data_ready, framing_error, overrun_error}, {m_ready, m_fe, m_ov});
    end
  endtask

  task automatic test_false_start();
    int p0, d0;
    logic seen_busy;
    p0 = pulse_q.size(); d0 = done_q.size(); seen_busy = 1'b0;
    repeat (3) begin @(negedge clk); serial_in = 1'b0; end
    @(negedge clk); serial_in = 1'b1;
    m_fe = 1'b0;
    repeat (40) begin @(negedge clk); if (busy === 1'b1) seen_busy = 1'b1; end
    compared++; if (seen_busy !== 1'b1) begin mismatched++; $display("FAIL glitch_start_seen: got busy %b want 1", seen_busy); end
    compared++; if (pulse_q.size() - p0 !== 0) begin mismatched++; $display("FAIL glitch_pulses: got %0d want 0", pulse_q.size() - p0); end
    compared++; if (done_q.size() - d0 !== 0) begin mismatched++; $display("FAIL glitch_done: got %0d want 0", done_q.size() - d0); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL glitch_idle: got busy %b want 0", busy); end
    compared++;
    if ({data_ready, framing_error, overrun_error} !== {m_ready, m_fe, m_ov}) begin
      mismatched++; $display("FAIL glitch_flags: got %b want %b", {data_ready, framing_error, overrun_error}, {m_ready, m_fe, m_ov});
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b0, 3, 0);
    compared++; if (o_np !== 8) begin mismatched++; $display("FAIL fe_pulses: got %0d want 8", o_np); end
    compared++; if (o_word !== 8'h3C) begin mismatched++; $display("FAIL fe_word: got %h want 3c", o_word); end
    compared++; if (o_nd !== 0) begin mismatched++; $display("FAIL fe_done: got %0d want 0", o_nd); end
    compared++;
    if ({data_ready, framing_error, overrun_error} !== {m_ready, m_fe, m_ov}) begin
      mismatched++; $display("FAIL fe_flags: got %b want %b", {data_ready, framing_error, overrun_error}, {m_ready, m_fe, m_ov});
    end
    send_frame(8'h5A, 1'b1, 1'b0, 3, 0);
    compared++; if (o_mid_fe !== 1'b0) begin mismatched++; $display("FAIL fe_clear_on_start: got %b want 0", o_mid_fe); end
    compared++; if (o_word !== 8'h5A || o_nd !== 1) begin mismatched++; $display("FAIL fe_next_good: got %h/%0d want 5a/1", o_word, o_nd); end
  endtask

  task automatic test_overrun();
    pulse_read();
    compared++; if ({data_ready, overrun_error} !== 2'b00) begin mismatched++; $display("FAIL read_clear0: got %b want 00", {data_ready, overrun_error}); end
    send_frame(8'h11, 1'b1, 1'b0, 2, 0);
    send_frame(8'h22, 1'b1, 1'b0, 2, 0);
    compared++;
    if ({data_ready, overrun_error} !== {m_ready, m_ov} || m_ov !== 1'b1) begin
      mismatched++; $display("FAIL overrun_set: got %b want %b", {data_ready, overrun_error}, {m_ready, m_ov});
    end
    pulse_read();
    compared++; if ({data_ready, overrun_error} !== 2'b00) begin mismatched++; $display("FAIL read_clear: got %b want 00", {data_ready, overrun_error}); end
    send_frame(8'h33, 1'b1, 1'b0, 2, 0);
    send_frame(8'h44, 1'b1, 1'b1, 2, 0);
    compared++;
    if ({data_ready, overrun_error} !== 2'b10) begin
      mismatched++; $display("FAIL read_at_done: got %b want 10", {data_ready, overrun_error});
    end
    compared++; if (o_word !== 8'h44) begin mismatched++; $display("FAIL read_at_done_word: got %h want 44", o_word); end
  endtask

  task automatic test_reset_mid();
    int p0, d0;
    logic [7:0] d;
    send_frame(8'h96, 1'b1, 1'b0, 0, 4);
    n_rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({shift_enable, sample_bit, packet_done, data_ready, framing_error, overrun_error, busy} !== 7'b0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got %b want 0000000",
               {shift_enable, sample_bit, packet_done, data_ready, framing_error, overrun_error, busy});
    end
    n_rst = 1'b1;
    m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    p0 = pulse_q.size(); d0 = done_q.size();
    repeat (120) @(negedge clk);
    compared++;
    if (pulse_q.size() - p0 !== 0 || done_q.size() - d0 !== 0) begin
      mismatched++; $display("FAIL midreset_quiet: got %0d pulses %0d done want 0 0", pulse_q.size() - p0, done_q.size() - d0);
    end
    d = 8'($urandom);
    send_frame(d, 1'b1, 1'b0, 3, 0);
    compared++;
    if (o_word !== d || o_np !== 8 || o_nd !== 1 || data_ready !== 1'b1) begin
      mismatched++; $display("FAIL midreset_recover: got %h/%0d/%0d/%b want %h/8/1/1", o_word, o_np, o_nd, data_ready, d);
    end
  endtask

  task automatic test_back_to_back();
    int p0, d0;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    p0 = pulse_q.size(); d0 = done_q.size();
    send_frame(a, 1'b1, 1'b0, 0, 0);
    compared++; if (o_word !== a) begin mismatched++; $display("FAIL b2b_word1: got %h want %h", o_word, a); end
    send_frame(b, 1'b1, 1'b0, 3, 0);
    compared++; if (o_word !== b) begin mismatched++; $display("FAIL b2b_word2: got %h want %h", o_word, b); end
    compared++;
    if (pulse_q.size() - p0 !== 16 || done_q.size() - d0 !== 2) begin
      mismatched++; $display("FAIL b2b_totals: got %0d pulses %0d done want 16 2", pulse_q.size() - p0, done_q.size() - d0);
    end
    compared++;
    if ({data_ready, framing_error, overrun_error} !== {m_ready, m_fe, m_ov}) begin
      mismatched++; $display("FAIL b2b_flags: got %b want %b", {data_ready, framing_error, overrun_error}, {m_ready, m_fe, m_ov});
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic stop, rd;
    int idle;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 2) == 0) pulse_read();
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rd   = stop && ($urandom_range(0, 1) == 1);
      idle = stop ? $urandom_range(0, 5) : $urandom_range(2, 5);
      send_frame(d, stop, rd, idle, 0);
      compared++;
      if (o_np !== 8 || o_word !== d || o_gaps_bad !== 0) begin
        mismatched++; $display("FAIL rnd_data[%0d]: got %0d/%h/%0d want 8/%h/0", n, o_np, o_word, o_gaps_bad, d);
      end
      compared++;
      if (o_nd !== int'(stop) || (stop && o_done_gap !== 10)) begin
        mismatched++; $display("FAIL rnd_done[%0d]: got %0d gap %0d want %0d gap 10", n, o_nd, o_done_gap, stop);
      end
      compared++;
      if ({data_ready, framing_error, overrun_error} !== {m_ready, m_fe, m_ov} || o_mid_fe !== 1'b0) begin
        mismatched++; $display("FAIL rnd_flags[%0d]: got %b/%b want %b/0", n,
                               {data_ready, framing_error, overrun_error}, o_mid_fe, {m_ready, m_fe, m_ov});
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_false_start();
    test_framing();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
